// File: rtl/alu_6502_pkg.sv
// Shared encodings for the 6502 ALU sequencer: one-hot ALU controls, command opcodes,
// FSM states and the carry-recovery helper (the ALU exposes no carry-out).
package alu_6502_pkg;

    localparam logic [4:0] ALU_SUMS = 5'b10000;
    localparam logic [4:0] ALU_ORS  = 5'b01000;
    localparam logic [4:0] ALU_XORS = 5'b00100;
    localparam logic [4:0] ALU_ANDS = 5'b00010;
    localparam logic [4:0] ALU_SRS  = 5'b00001;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_OR    = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_SHR   = 3'b101;
    localparam logic [2:0] OP_ADD16 = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_HI, S_INC, S_DONE} state_t;

    // Carry out of an 8-bit add rebuilt from the operand and result sign bits.
    function automatic logic add_carry(input logic a7, input logic b7, input logic r7);
        return (a7 & b7) | ((a7 | b7) & ~r7);
    endfunction

    function automatic logic [4:0] op_ctrl(input logic [2:0] op);
        case (op)
            OP_ADD, OP_ADD16: op_ctrl = ALU_SUMS;
            OP_OR:            op_ctrl = ALU_ORS;
            OP_XOR:           op_ctrl = ALU_XORS;
            OP_SHR:           op_ctrl = ALU_SRS;
            default:          op_ctrl = ALU_ANDS;
        endcase
    endfunction

endpackage

// File: rtl/alu_6502_seq.sv
// Command sequencer driving an external 8-bit 6502 ALU; one pass per cycle,
// chaining EXEC/HI/INC passes to build a 16-bit add.
module alu_6502_seq
    import alu_6502_pkg::*;
#(
    parameter bit ADD16_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_operand,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_ctrl,
    input  logic [7:0]  alu_result,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c
);

    state_t      state, state_nxt;
    logic [2:0]  op;
    logic [7:0]  operand_hi;
    logic [7:0]  acc, acc_hi;
    logic        c_lo;
    logic [7:0]  a_nxt, b_nxt;
    logic [4:0]  ctrl_nxt;
    logic        accept;
    logic [2:0]  op_eff;
    logic        pass_c;

    assign cmd_ready = (state == S_IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_valid = (state == S_DONE);
    assign pass_c    = add_carry(alu_a[7], alu_b[7], alu_result[7]);
    assign op_eff    = (cmd_op == OP_ADD16 && !ADD16_EN) ? OP_ADD : cmd_op;

    // Next state plus the operands for the next pass; idle passes park on AND,0,0.
    always_comb begin
        state_nxt = state;
        a_nxt     = 8'h00;
        b_nxt     = 8'h00;
        ctrl_nxt  = ALU_ANDS;
        case (state)
            S_IDLE: if (accept) begin
                if (op_eff == OP_LOAD || op_eff == OP_CLR) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_EXEC;
                    a_nxt     = acc;
                    b_nxt     = cmd_operand[7:0];
                    ctrl_nxt  = op_ctrl(op_eff);
                end
            end
            S_EXEC: if (op == OP_ADD16) begin
                state_nxt = S_HI;
                a_nxt     = acc_hi;
                b_nxt     = operand_hi;
                ctrl_nxt  = ALU_SUMS;
            end else begin
                state_nxt = S_DONE;
            end
            S_HI: if (c_lo) begin
                state_nxt = S_INC;
                a_nxt     = alu_result;
                b_nxt     = 8'h01;
                ctrl_nxt  = ALU_SUMS;
            end else begin
                state_nxt = S_DONE;
            end
            S_INC:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= OP_LOAD;
            operand_hi <= 8'h00;
            acc        <= 8'h00;
            acc_hi     <= 8'h00;
            c_lo       <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_ctrl   <= ALU_ANDS;
            rsp_data   <= 16'h0000;
            flag_n     <= 1'b0;
            flag_z     <= 1'b0;
            flag_v     <= 1'b0;
            flag_c     <= 1'b0;
        end else begin
            state    <= state_nxt;
            alu_a    <= a_nxt;
            alu_b    <= b_nxt;
            alu_ctrl <= ctrl_nxt;
            case (state)
                S_IDLE: if (accept) begin
                    op         <= op_eff;
                    operand_hi <= cmd_operand[15:8];
                    if (op_eff == OP_LOAD) begin
                        acc      <= cmd_operand[7:0];
                        acc_hi   <= cmd_operand[15:8];
                        flag_n   <= cmd_operand[7];
                        flag_z   <= (cmd_operand[7:0] == 8'h00);
                        rsp_data <= cmd_operand;
                    end else if (op_eff == OP_CLR) begin
                        acc      <= 8'h00;
                        acc_hi   <= 8'h00;
                        flag_n   <= 1'b0;
                        flag_z   <= 1'b0;
                        flag_v   <= 1'b0;
                        flag_c   <= 1'b0;
                        rsp_data <= 16'h0000;
                    end
                end
                S_EXEC: begin
                    acc <= alu_result;
                    if (op == OP_ADD16) begin
                        c_lo <= pass_c;
                    end else begin
                        flag_n   <= alu_result[7];
                        flag_z   <= (alu_result == 8'h00);
                        rsp_data <= {acc_hi, alu_result};
                        if (op == OP_ADD) begin
                            flag_v <= alu_overflow;
                            flag_c <= pass_c;
                        end
                    end
                end
                S_HI: begin
                    acc_hi   <= alu_result;
                    flag_n   <= alu_result[7];
                    flag_z   <= ({alu_result, acc} == 16'h0000);
                    flag_v   <= alu_overflow;
                    flag_c   <= pass_c;
                    rsp_data <= {alu_result, acc};
                end
                // Low-pass carry only bumps the high byte; its own carry/overflow OR into HI's.
                S_INC: begin
                    acc_hi   <= alu_result;
                    flag_n   <= alu_result[7];
                    flag_z   <= ({alu_result, acc} == 16'h0000);
                    flag_v   <= flag_v | alu_overflow;
                    flag_c   <= flag_c | pass_c;
                    rsp_data <= {alu_result, acc};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_6502_seq.sv
// Scoreboard bench for alu_6502_seq with a behavioural ALU sibling model.
module tb_alu_6502_seq;
    import alu_6502_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'b000;
    logic [15:0] cmd_operand = 16'h0000;
    logic [7:0]  alu_a, alu_b;
    logic [4:0]  alu_ctrl;
    logic [7:0]  alu_result;
    logic        alu_overflow;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        flag_n, flag_z, flag_v, flag_c;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  f;
        int          lat;
        int          t;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   oh_err = 0;
    int   accepts = 0;
    int   sent = 0;

    alu_6502_seq #(.ADD16_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .flag_c(flag_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sibling ALU: combinational from the registered operands.
    always_comb begin
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            5'b10000: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
            end
            5'b01000: alu_result = alu_a | alu_b;
            5'b00100: alu_result = alu_a ^ alu_b;
            5'b00010: alu_result = alu_a & alu_b;
            5'b00001: alu_result = (alu_b >= 8'd8) ? 8'h00 : (alu_a >> alu_b);
            default:  alu_result = 8'h00;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) if (!rst && cmd_valid && cmd_ready) accepts++;

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        if (!$onehot(alu_ctrl)) oh_err++;
        if (!rst && rsp_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_data", {16'h0, rsp_data}, {16'h0, e.d});
                check("flags_nzvc", {28'h0, flag_n, flag_z, flag_v, flag_c}, {28'h0, e.f});
                check("latency", cyc - e.t, e.lat);
            end
        end
    end

    // Drive a command from a negedge and leave cmd_valid high afterwards.
    task automatic send(input logic [2:0] op, input logic [15:0] opnd,
                        input logic [15:0] d, input logic [3:0] f, input int lat);
        int g = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_operand = opnd;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            sbq.push_back('{d, f, lat, cyc});
            sent++;
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        @(negedge clk);
        @(negedge clk);
        check("ready_in_reset", {31'h0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'h0, cmd_ready}, 32'd1);
        check("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
        check("reset_flags", {28'h0, flag_n, flag_z, flag_v, flag_c}, 32'h0);
        check("reset_alu_ctrl", {27'h0, alu_ctrl}, 32'h2);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);

        //   op        operand     rsp       NZVC     lat
        send(OP_LOAD,  16'h0050, 16'h0050, 4'b0000, 1);
        send(OP_ADD,   16'h0050, 16'h00A0, 4'b1010, 2);
        check("exec_ctrl", {27'h0, alu_ctrl}, 32'h10);
        check("exec_a", {24'h0, alu_a}, 32'h50);
        check("exec_b", {24'h0, alu_b}, 32'h50);
        send(OP_LOAD,  16'h12FF, 16'h12FF, 4'b1010, 1);
        send(OP_ADD16, 16'h0001, 16'h1300, 4'b0000, 4);
        send(OP_LOAD,  16'hFFFF, 16'hFFFF, 4'b1000, 1);
        send(OP_ADD16, 16'h0001, 16'h0000, 4'b0101, 4);
        send(OP_LOAD,  16'h1000, 16'h1000, 4'b0101, 1);
        send(OP_ADD16, 16'h0100, 16'h1100, 4'b0000, 3);
        send(OP_LOAD,  16'h0080, 16'h0080, 4'b1000, 1);
        send(OP_ADD,   16'h0080, 16'h0000, 4'b0111, 2);
        send(OP_LOAD,  16'h0080, 16'h0080, 4'b1011, 1);
        send(OP_SHR,   16'h0003, 16'h0010, 4'b0011, 2);
        send(OP_SHR,   16'h0009, 16'h0000, 4'b0111, 2);
        send(OP_LOAD,  16'h3C5A, 16'h3C5A, 4'b0011, 1);
        send(OP_OR,    16'h00A0, 16'h3CFA, 4'b1011, 2);
        send(OP_XOR,   16'h00FA, 16'h3C00, 4'b0111, 2);
        send(OP_OR,    16'h000F, 16'h3C0F, 4'b0011, 2);
        send(OP_AND,   16'h003C, 16'h3C0C, 4'b0011, 2);
        send(OP_CLR,   16'h0000, 16'h0000, 4'b0000, 1);
        send(OP_LOAD,  16'h12FF, 16'h12FF, 4'b1000, 1);

        // ADD16 abandoned by reset during its HI pass: no response expected.
        cmd_valid = 1'b1;
        cmd_op = OP_ADD16;
        cmd_operand = 16'h0001;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("abort_accept", {31'h0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("hi_ctrl", {27'h0, alu_ctrl}, 32'h10);
        check("hi_a", {24'h0, alu_a}, 32'h12);
        rst = 1'b1;
        @(negedge clk);
        check("ready_mid_reset", {31'h0, cmd_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_abort", {31'h0, cmd_ready}, 32'd1);
        check("abort_rsp_data", {16'h0, rsp_data}, 32'h0);
        check("abort_alu_ctrl", {27'h0, alu_ctrl}, 32'h2);
        repeat (3) @(negedge clk);

        send(OP_LOAD,  16'h0042, 16'h0042, 4'b0000, 1);
        send(OP_ADD,   16'h0001, 16'h0043, 4'b0000, 2);
        cmd_valid = 1'b0;

        g = 0;
        while (sbq.size() > 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("scoreboard_drain", sbq.size(), 32'd0);
        check("accept_count", accepts, sent + 1);
        check("onehot_violations", oh_err, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_6502_seq.md
Name: alu_6502_seq

Overview:
- Command sequencer that owns the 8-bit 6502 ALU datapath.
- Accepts one operation at a time over a valid/ready handshake and holds an accumulator pair (acc_hi:acc) plus N/Z/V/C flags.
- Drives the ALU one-hot control and operands, one ALU pass per cycle, and chains up to three passes to build a 16-bit add. The ALU itself has no carry-in.
- Sits beside the ALU in the parent subsystem; the ALU is instantiated by the parent and connected through the alu_* ports.

Parameters:
- ADD16_EN, 1, when 0 opcode ADD16 executes as 8-bit ADD.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; = (state==IDLE) & ~rst
- cmd_op  in  3  000 LOAD, 001 ADD, 010 OR, 011 XOR, 100 AND, 101 SHR, 110 ADD16, 111 CLR
- cmd_operand  in  16  operand; [7:0] only for 8-bit ops and SHR amount
- alu_a  out  8  ALU regA (registered)
- alu_b  out  8  ALU regB (registered)
- alu_ctrl  out  5  ALU one-hot control (registered)
- alu_result  in  8  ALU regOut (combinational from alu_a/b/ctrl)
- alu_overflow  in  1  ALU signed overflow
- rsp_valid  out  1  one-cycle pulse, operation complete
- rsp_data  out  16  {acc_hi, acc}; held between responses
- flag_n, flag_z, flag_v, flag_c  out  1 each  status flags

Behaviour:
- Reset:
  - state=IDLE; acc, acc_hi, rsp_data, all flags, rsp_valid = 0.
  - alu_a = alu_b = 0; alu_ctrl = 5'b00010 (AND).
  - Reset mid-operation abandons the command with no response.
- alu_ctrl is always exactly one-hot. Non-one-hot codes are forbidden because the ALU mux latches on them. It returns to AND, 0, 0 whenever no pass is active.
- Acceptance: cmd_valid & cmd_ready in cycle T latches op and operand.
- States: IDLE, EXEC, HI, INC, DONE.
  - IDLE -> DONE for LOAD/CLR; IDLE -> EXEC otherwise.
  - EXEC -> HI for ADD16 (ADD16_EN=1); EXEC -> DONE otherwise.
  - HI -> INC if the low carry is set, else HI -> DONE.
  - INC -> DONE.
  - DONE -> IDLE, with rsp_valid=1 for exactly this cycle.
- Latency (rsp_valid cycle):
  - LOAD/CLR: T+1.
  - 8-bit ops: T+2.
  - ADD16: T+3 without low carry, T+4 with it.
- Throughput: the next command is accepted no earlier than the IDLE cycle after DONE. cmd_ready is low in EXEC/HI/INC/DONE.
- ALU pass: in EXEC/HI/INC, alu_* are presented at cycle start; alu_result and alu_overflow are captured at the end of the same cycle.
- Pass operands:
  - EXEC: a=acc, b=operand[7:0].
  - HI: a=acc_hi, b=operand[15:8].
  - INC: a=acc_hi (HI result), b=8'h01, ctrl=SUMS.
- SHR: ctrl=SRS, b=shift amount; an amount of 8 or more yields 0 (ALU semantics).
- Carry recovery per add pass: c = (a7&b7) | ((a7|b7) & ~r7).
- Register updates:
  - 8-bit ops: result -> acc; acc_hi unchanged.
  - ADD16: EXEC -> acc, HI/INC -> acc_hi.
  - LOAD: acc=operand[7:0], acc_hi=operand[15:8].
  - CLR: acc, acc_hi and all flags = 0.
- Flags, updated when leaving EXEC/HI/INC (LOAD in IDLE):
  - 8-bit ops and LOAD: N=acc[7], Z=(acc==0).
  - ADD16: N=acc_hi[7], Z=({acc_hi,acc}==0).
  - ADD: V=alu_overflow, C=carry.
  - ADD16: V = v_hi | v_inc; C = c_hi | c_inc (the low-pass carry feeds INC only).
  - OR/XOR/AND/SHR/LOAD preserve V and C.
- rsp_data updates on entering DONE.

Decomposition:
- Package alu_6502_pkg:
  - one-hot ALU control constants (SUMS, ORS, XORS, ANDS, SRS);
  - cmd_op encodings;
  - state enum;
  - pure function add_carry(a7, b7, r7).
- No sub-module: single FSM plus registers. The ALU stays a sibling instance in the parent.

Test Plan:
- Reset: rst high for 2 cycles, then low -> cmd_ready 0 during reset and 1 after; rsp_data 0x0000, all flags 0, alu_ctrl 5'b00010, no rsp_valid.
- LOAD 0x0050 at T, then ADD 0x0050 at T' -> during EXEC alu_ctrl=10000, a=b=0x50; rsp_valid at T'+2; acc 0xA0, N=1, Z=0, V=1, C=0.
- LOAD 0x12FF, then ADD16 0x0001 -> passes EXEC 0xFF+0x01=0x00 (c=1), HI 0x12+0x00, INC 0x13; rsp_valid at T+4; rsp_data 0x1300, N=0, Z=0, C=0, V=0.
- LOAD 0xFFFF, then ADD16 0x0001 -> rsp_data 0x0000, Z=1, C=1, V=0.
- Second check: LOAD 0x1000, then ADD16 0x0100 -> no INC, rsp_valid at T+3, rsp_data 0x1100.
- LOAD 0x0080 with C=1 preset by a prior ADD:
  - SHR 0x03 -> acc 0x10, Z=0.
  - SHR 0x09 -> acc 0x00, Z=1.
  - C and V unchanged throughout.
- Back-pressure/reset: hold cmd_valid across a busy ADD16 -> exactly one acceptance per IDLE cycle. Assert rst during HI -> no rsp_valid and state IDLE. The next command completes normally.
